debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Parametrised multi-channel button conditioner: synchronises, debounces and edge-detects N raw
//  button/keyboard levels, with optional per-channel auto-repeat (typematic) strobes. Sits between
//  the ps2_key/joystick decode in emu and menu/difficulty/toggle logic; replaces per-button debounce.
// PARAMETERS
//  CHANNELS       8           number of independent button channels (>=1)
//  CNT_W          10          settle counter width; new level must be stable 2^CNT_W cycles (>=2)
//  ACTIVE_LOW     0           1: i_btn is active-low (inverted after synchroniser)
//  REPEAT_DELAY   12_000_000  cycles from press pulse to first repeat pulse (>=2; 0.5 s @ 24 MHz)
//  REPEAT_PERIOD  2_400_000   cycles between subsequent repeat pulses (>=2; 0.1 s @ 24 MHz)
// PORTS
//  clk          in   1         system clock (clk_sys)
//  reset        in   1         asynchronous, active-high reset
//  i_btn        in   CHANNELS  raw button levels, asynchronous to clk
//  i_repeat_en  in   CHANNELS  per-channel auto-repeat enable (synchronous to clk)
//  o_state      out  CHANNELS  debounced level, 1 = pressed
//  o_ondn       out  CHANNELS  1-cycle pulse on debounced press (o_state 0->1)
//  o_onup       out  CHANNELS  1-cycle pulse on debounced release (o_state 1->0)
//  o_rpt        out  CHANNELS  1-cycle auto-repeat pulse while held
//  o_strobe     out  CHANNELS  o_ondn | o_rpt (combinational OR of registered pulses)
// BEHAVIOUR
//  Reset: one clock, asynchronous active-high. All outputs, counters, FSMs -> 0; synchroniser flops
//   reset to raw idle level (0, or 1 if ACTIVE_LOW) so no spurious press follows reset.
//  Per channel, fully independent; no shared state between channels.
//  Sync: 2-flop synchroniser, then invert if ACTIVE_LOW -> s.
//  Debounce: idle = (s == o_state). idle -> cnt <= 0. Not idle -> cnt <= cnt+1; when cnt all-ones,
//   o_state <= ~o_state and cnt <= 0 on the same edge.
//  Latency: counting the edge that first samples a stable new level as edge 1, o_state toggles on
//   edge 2^CNT_W + 2. A level that reverts before then clears cnt; no toggle, no pulse.
//  o_ondn/o_onup: registered, asserted exactly in the cycle the new o_state is first visible, 1 cycle.
//  Repeat FSM (states IDLE, DELAY, REPEAT; timer width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD))):
//   IDLE  -> DELAY on the press toggle edge if i_repeat_en=1; timer <= 0.
//   DELAY: timer++; at timer==REPEAT_DELAY-1 pulse o_rpt, timer <= 0, -> REPEAT.
//   REPEAT: timer++; at timer==REPEAT_PERIOD-1 pulse o_rpt, timer <= 0.
//   Any state -> IDLE (timer 0, no o_rpt that cycle) when release toggle occurs or i_repeat_en=0.
//   First o_rpt exactly REPEAT_DELAY cycles after o_ondn; then every REPEAT_PERIOD cycles.
//   Raising i_repeat_en while already held does not start repeat; next press does.
//  o_ondn and o_rpt never coincide; o_strobe is therefore one pulse per event.
//  Reset mid-hold: outputs drop immediately; if still held after reset, a fresh o_ondn follows after
//   full debounce latency (no o_onup is generated for the aborted press).
//  Simultaneous events on different channels are processed in the same cycle with no arbitration.
// TESTING (CHANNELS=4, CNT_W=4, REPEAT_DELAY=40, REPEAT_PERIOD=10, ACTIVE_LOW=0 unless noted)
//  1 Clean press ch0 0->1 held -> o_state[0] rises on edge 18, o_ondn[0] 1 cycle; ch1..3 stay 0.
//  2 Bounce ch0: 1 for 10 cycles, 0 for 5, 1 for 15, then 0 -> no toggle, no ondn/onup/rpt.
//  3 Repeat ch1 (i_repeat_en[1]=1) held 75 cycles past o_ondn -> o_rpt at +40,+50,+60,+70 (4 pulses);
//    release -> o_onup after 18 edges, no further o_rpt; o_strobe shows 5 pulses total.
//  4 i_repeat_en=0, ch2 held 200 cycles -> single o_ondn, zero o_rpt; then ch2+ch3 pressed same
//    edge -> both o_ondn in same cycle.
//  5 Reset asserted during REPEAT with ch1 held -> all outputs 0 asynchronously; after deassert,
//    o_ondn[1] again on edge 18, no o_onup; ACTIVE_LOW=1 instance with i_btn='1 -> no pulses.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel button conditioner.
// Each channel synchronises a raw button level, debounces it with a settle
// counter, produces registered press/release pulses and an optional
// typematic auto-repeat pulse train. Channels share no state.
module debounce_bank #(
    parameter int CHANNELS      = 8,
    parameter int CNT_W         = 10,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = 12_000_000,
    parameter int REPEAT_PERIOD = 2_400_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_btn,
    input  logic [CHANNELS-1:0] i_repeat_en,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_ondn,
    output logic [CHANNELS-1:0] o_onup,
    output logic [CHANNELS-1:0] o_rpt,
    output logic [CHANNELS-1:0] o_strobe
);

    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // Raw level of a released button; the synchroniser resets to it.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] w_lvl;

    // Two-flop synchroniser for all raw button inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: reset to the idle raw level, not to 0, so an active-low
            // bank does not see a phantom press right after reset.
            r_sync1 <= {CHANNELS{IDLE_LVL}};
            r_sync2 <= {CHANNELS{IDLE_LVL}};
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity: 1 = pressed from here on.
    assign w_lvl = r_sync2 ^ {CHANNELS{IDLE_LVL}};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_state;
        logic             r_ondn;
        logic             r_onup;
        logic             r_rpt;
        rpt_state_t       r_fsm;
        rpt_state_t       w_nxt_fsm;
        logic [TMR_W-1:0] r_tmr;
        logic [TMR_W-1:0] w_nxt_tmr;
        logic             w_toggle;
        logic             w_press;
        logic             w_release;
        logic             w_fire;

        // A toggle happens when the level has disagreed for 2^CNT_W counts.
        assign w_toggle  = (w_lvl[g] != r_state) && (r_cnt == {CNT_W{1'b1}});
        assign w_press   = w_toggle & ~r_state;
        assign w_release = w_toggle &  r_state;

        // Settle counter, debounced level and registered edge pulses.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
                r_ondn  <= 1'b0;
                r_onup  <= 1'b0;
            end else begin
                r_ondn <= w_press;
                r_onup <= w_release;
                if (w_lvl[g] == r_state) begin
                    r_cnt <= '0;
                end else if (w_toggle) begin
                    r_cnt   <= '0;
                    r_state <= ~r_state;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        // Repeat FSM state register, timer and registered repeat pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_fsm <= ST_IDLE;
                r_tmr <= '0;
                r_rpt <= 1'b0;
            end else begin
                r_fsm <= w_nxt_fsm;
                r_tmr <= w_nxt_tmr;
                r_rpt <= w_fire;
            end
        end

        // Repeat FSM next-state and next-timer logic.
        always_comb begin
            // NOTE: defaults first so every path assigns every output and
            // no latch is inferred.
            w_nxt_fsm = r_fsm;
            w_nxt_tmr = r_tmr + TMR_W'(1);
            if (!i_repeat_en[g] || w_release) begin
                w_nxt_fsm = ST_IDLE;
                w_nxt_tmr = '0;
            end else begin
                case (r_fsm)
                    ST_IDLE: begin
                        w_nxt_tmr = '0;
                        if (w_press) begin
                            w_nxt_fsm = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (r_tmr == DELAY_LAST) begin
                            w_nxt_fsm = ST_REPEAT;
                            w_nxt_tmr = '0;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_tmr == PERIOD_LAST) begin
                            w_nxt_tmr = '0;
                        end
                    end
                    default: begin
                        w_nxt_fsm = ST_IDLE;
                        w_nxt_tmr = '0;
                    end
                endcase
            end
        end

        // Repeat FSM output: fire when the current interval expires.
        always_comb begin
            w_fire = 1'b0;
            if (i_repeat_en[g] && !w_release) begin
                if ((r_fsm == ST_DELAY) && (r_tmr == DELAY_LAST)) begin
                    w_fire = 1'b1;
                end else if ((r_fsm == ST_REPEAT) && (r_tmr == PERIOD_LAST)) begin
                    w_fire = 1'b1;
                end
            end
        end

        assign o_state[g] = r_state;
        assign o_ondn[g]  = r_ondn;
        assign o_onup[g]  = r_onup;
        assign o_rpt[g]   = r_rpt;
    end

    // Press and repeat pulses never coincide, so this is one pulse per event.
    assign o_strobe = o_ondn | o_rpt;

endmodule

// File: tb/tb_debounce_bank.sv
// Testbench for debounce_bank: hand sequences, a phase table with expected
// pulse counts, and random stimulus checked against an event-level model.
module tb_debounce_bank;

    localparam int CH  = 4;
    localparam int CW  = 4;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int SET = 16;   // 2^CW settle cycles

    logic          clk;
    logic          reset;
    logic [CH-1:0] btn, en;
    logic [CH-1:0] o_state, o_ondn, o_onup, o_rpt, o_strobe;
    logic [CH-1:0] al_btn, al_en;
    logic [CH-1:0] al_state, al_ondn, al_onup, al_rpt, al_strobe;

    debounce_bank #(
        .CHANNELS(CH), .CNT_W(CW), .ACTIVE_LOW(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .i_btn(btn), .i_repeat_en(en),
        .o_state(o_state), .o_ondn(o_ondn), .o_onup(o_onup),
        .o_rpt(o_rpt), .o_strobe(o_strobe)
    );

    debounce_bank #(
        .CHANNELS(CH), .CNT_W(CW), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_al (
        .clk(clk), .reset(reset), .i_btn(al_btn), .i_repeat_en(al_en),
        .o_state(al_state), .o_ondn(al_ondn), .o_onup(al_onup),
        .o_rpt(al_rpt), .o_strobe(al_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    // A channel toggles once its synchronised level has disagreed with the
    // debounced level for SET consecutive edges. Repeats are scheduled at
    // press + RD + k*RP while the press is held with enable continuously on.
    logic [CH-1:0] m_sy1, m_sy2, m_state, m_ondn, m_onup, m_rpt;
    int            m_cyc;
    int            m_idle  [CH];
    int            m_press [CH];
    bit            m_on    [CH];

    task automatic model_reset();
        m_sy1 = '0; m_sy2 = '0; m_state = '0;
        m_ondn = '0; m_onup = '0; m_rpt = '0;
        m_cyc = 0;
        for (int c = 0; c < CH; c++) begin
            m_idle[c] = 0; m_press[c] = 0; m_on[c] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] b, input logic [CH-1:0] e);
        bit tg;
        int d;
        m_cyc++;
        for (int c = 0; c < CH; c++) begin
            m_ondn[c] = 1'b0; m_onup[c] = 1'b0; m_rpt[c] = 1'b0;
            tg = 1'b0;
            if (m_sy2[c] == m_state[c]) begin
                m_idle[c] = m_cyc;
            end else if (m_cyc - m_idle[c] == SET) begin
                tg = 1'b1;
                m_idle[c] = m_cyc;
            end
            if (m_on[c]) begin
                if (!e[c] || (tg && m_state[c])) begin
                    m_on[c] = 1'b0;
                end else begin
                    d = m_cyc - m_press[c];
                    if (d == RD || (d > RD && (d - RD) % RP == 0)) m_rpt[c] = 1'b1;
                end
            end else if (tg && !m_state[c] && e[c]) begin
                m_on[c]    = 1'b1;
                m_press[c] = m_cyc;
            end
            if (tg) begin
                m_ondn[c]  = ~m_state[c];
                m_onup[c]  =  m_state[c];
                m_state[c] = ~m_state[c];
            end
        end
        m_sy2 = m_sy1;
        m_sy1 = b;
    endtask

    // ---------------- clocking helper ----------------
    int c_ondn, c_onup, c_rpt, c_strobe;
    bit al_quiet = 1'b1;

    task automatic clear_counts();
        c_ondn = 0; c_onup = 0; c_rpt = 0; c_strobe = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(btn, en);
        #1;
        check("cycle_vs_model",
              32'({o_state, o_ondn, o_onup, o_rpt, o_strobe}),
              32'({m_state, m_ondn, m_onup, m_rpt, m_ondn | m_rpt}));
        if (al_quiet) begin
            check("active_low_quiet",
                  32'({al_state, al_ondn, al_onup, al_rpt, al_strobe}), 32'd0);
        end
        c_ondn   += $countones(o_ondn);
        c_onup   += $countones(o_onup);
        c_rpt    += $countones(o_rpt);
        c_strobe += $countones(o_strobe);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- phase table ----------------
    typedef struct {
        string         name;
        logic [CH-1:0] b;
        logic [CH-1:0] e;
        int            cycles;
        logic [CH-1:0] exp_state;
        int            exp_ondn;
        int            exp_onup;
        int            exp_rpt;
        int            exp_strobe;
    } phase_t;

    phase_t tbl[18];

    int rh[CH];
    int ei;

    initial begin
        tbl[0]  = '{"press0",   4'b0001, 4'b0000, 30,  4'b0001, 1, 0, 0, 1};
        tbl[1]  = '{"rel0",     4'b0000, 4'b0000, 30,  4'b0000, 0, 1, 0, 0};
        tbl[2]  = '{"bounce_a", 4'b0001, 4'b0000, 10,  4'b0000, 0, 0, 0, 0};
        tbl[3]  = '{"bounce_b", 4'b0000, 4'b0000, 5,   4'b0000, 0, 0, 0, 0};
        tbl[4]  = '{"bounce_c", 4'b0001, 4'b0000, 15,  4'b0000, 0, 0, 0, 0};
        tbl[5]  = '{"bounce_d", 4'b0000, 4'b0000, 30,  4'b0000, 0, 0, 0, 0};
        tbl[6]  = '{"rpt_hold", 4'b0010, 4'b0010, 75,  4'b0010, 1, 0, 2, 3};
        tbl[7]  = '{"rpt_rel",  4'b0000, 4'b0010, 40,  4'b0000, 0, 1, 2, 2};
        tbl[8]  = '{"norpt",    4'b0100, 4'b0000, 200, 4'b0100, 1, 0, 0, 1};
        tbl[9]  = '{"rel2",     4'b0000, 4'b0000, 30,  4'b0000, 0, 1, 0, 0};
        tbl[10] = '{"dual",     4'b1100, 4'b0000, 30,  4'b1100, 2, 0, 0, 2};
        tbl[11] = '{"rel23",    4'b0000, 4'b0000, 30,  4'b0000, 0, 2, 0, 0};
        tbl[12] = '{"hold_noen",4'b0001, 4'b0000, 30,  4'b0001, 1, 0, 0, 1};
        tbl[13] = '{"en_late",  4'b0001, 4'b0001, 60,  4'b0001, 0, 0, 0, 0};
        tbl[14] = '{"rel_en",   4'b0000, 4'b0001, 30,  4'b0000, 0, 1, 0, 0};
        tbl[15] = '{"press_en", 4'b0001, 4'b0001, 70,  4'b0001, 1, 0, 2, 3};
        tbl[16] = '{"en_drop",  4'b0001, 4'b0000, 30,  4'b0001, 0, 0, 0, 0};
        tbl[17] = '{"rel_last", 4'b0000, 4'b0000, 30,  4'b0000, 0, 1, 0, 0};

        reset  = 1'b1;
        btn    = '0;
        en     = '0;
        al_btn = '1;
        al_en  = '0;
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        #1;
        check("reset_main", 32'({o_state, o_ondn, o_onup, o_rpt, o_strobe}), 32'd0);
        check("reset_al", 32'({al_state, al_ondn, al_onup, al_rpt, al_strobe}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Clean press on ch0: toggle exactly on edge 18, one-cycle ondn.
        btn = 4'b0001;
        ticks(17);
        check("t1_edge17_state", 32'(o_state), 32'd0);
        tick();
        check("t1_edge18_state", 32'(o_state), 32'h1);
        check("t1_edge18_ondn",  32'(o_ondn),  32'h1);
        tick();
        check("t1_ondn_1cycle",  32'(o_ondn),  32'h0);
        btn = 4'b0000;
        ticks(30);

        // Table-driven phases with expected pulse counts.
        for (int i = 0; i < 18; i++) begin
            btn = tbl[i].b;
            en  = tbl[i].e;
            clear_counts();
            ticks(tbl[i].cycles);
            check({tbl[i].name, "_state"},  32'(o_state), 32'(tbl[i].exp_state));
            check({tbl[i].name, "_ondn"},   32'(c_ondn),   32'(tbl[i].exp_ondn));
            check({tbl[i].name, "_onup"},   32'(c_onup),   32'(tbl[i].exp_onup));
            check({tbl[i].name, "_rpt"},    32'(c_rpt),    32'(tbl[i].exp_rpt));
            check({tbl[i].name, "_strobe"}, 32'(c_strobe), 32'(tbl[i].exp_strobe));
        end

        // Reset during REPEAT with ch1 held: outputs drop asynchronously,
        // fresh press after full latency, no release pulse.
        btn = 4'b0010;
        en  = 4'b0010;
        clear_counts();
        ticks(63);
        check("t5_held_state", 32'(o_state), 32'h2);
        check("t5_rpt_seen",   32'(c_rpt),   32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_clear", 32'({o_state, o_ondn, o_onup, o_rpt, o_strobe}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_counts();
        ticks(17);
        check("t5_edge17_ondn", 32'(o_ondn), 32'h0);
        tick();
        check("t5_edge18_ondn", 32'(o_ondn), 32'h2);
        ticks(20);
        check("t5_no_onup", 32'(c_onup), 32'd0);
        btn = '0;
        en  = '0;
        ticks(30);

        // Randomised stimulus against the model.
        en = 4'b1111;
        for (int c = 0; c < CH; c++) rh[c] = $urandom_range(1, 60);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (rh[c] == 0) begin
                    btn[c] = ~btn[c];
                    if ($urandom_range(0, 3) == 0) rh[c] = $urandom_range(1, 20);
                    else                           rh[c] = $urandom_range(18, 120);
                end else begin
                    rh[c]--;
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                ei = $urandom_range(0, CH - 1);
                en[ei] = ~en[ei];
            end
            tick();
        end
        btn = '0;
        ticks(40);

        // Active-low bank: pulling ch0 low is a press.
        al_quiet = 1'b0;
        al_btn   = 4'b1110;
        ticks(20);
        check("al_press_state", 32'(al_state), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
